mem_stage: RTL and testbench

Pipeline stage directly downstream of EX. Registers EX results, issues loads and stores to data memory over a valid/ready handshake, and aligns and extends load data. Holds the pipeline with o_stall while an access is outstanding. Forwards pc/instr/dest info and the ALU result to the WB stage.

---
 rtl/mem_stage_pkg.sv | 44 ++++
 rtl/mem_stage_load_align.sv | 31 +++
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, memory access codes and state encodings for the MEM stage
package mem_stage_pkg;

    // Datapath widths shared with the rest of the pipeline
    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int INSTR_W     = 32;
    localparam int REG_IDX_W   = 5;
    localparam int DEST_SRC_W  = 2;
    localparam int MEM_COUNT_W = 2;

    // Instruction bit that selects zero extension for loads
    localparam int INSTR_UNSIGNED_BIT = 14;

    // Writeback source select value meaning "no register write"
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = '0;

    // Access size of a memory operation
    typedef enum logic [MEM_COUNT_W-1:0] {
        MEM_COUNT_NONE = 2'd0,
        MEM_COUNT_BYTE = 2'd1,
        MEM_COUNT_HALF = 2'd2,
        MEM_COUNT_WORD = 2'd3
    } mem_count_t;

    // Stage control states
    typedef enum logic {
        MEM_ST_IDLE = 1'b0,
        MEM_ST_BUSY = 1'b1
    } mem_state_t;

    // A halfword must sit on an even address, a word on a multiple of four
    function automatic logic is_misaligned(input mem_count_t count, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (count)
            MEM_COUNT_HALF: mis = addr_lo[0];
            MEM_COUNT_WORD: mis = (addr_lo != 2'b00);
            default:        mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - selects the addressed lane of a read word and sign/zero extends it
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [WORD_W-1:0] rd_word,
    input  logic [1:0]        addr_lo,
    input  mem_count_t        count,
    input  logic              is_unsigned,
    output logic [WORD_W-1:0] data
);

    logic [WORD_W-1:0] lane;

    // Shift the addressed byte lane down to bit 0, then extend by access size
    always_comb begin
        lane = rd_word >> {addr_lo, 3'b000};
        data = rd_word;
        case (count)
            MEM_COUNT_BYTE: begin
                if (is_unsigned) data = {{(WORD_W-8){1'b0}}, lane[7:0]};
                else             data = {{(WORD_W-8){lane[7]}}, lane[7:0]};
            end
            MEM_COUNT_HALF: begin
                if (is_unsigned) data = {{(WORD_W-16){1'b0}}, lane[15:0]};
                else             data = {{(WORD_W-16){lane[15]}}, lane[15:0]};
            end
            default: data = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: registers EX results, runs data memory handshake, aligns loads
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_BE_W = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   i_stall,
    input  logic [ADDR_W-1:0]      i_pc,
    input  logic [INSTR_W-1:0]     i_instr,
    input  logic [DEST_SRC_W-1:0]  i_dest_src,
    input  logic [REG_IDX_W-1:0]   i_dest_reg,
    input  logic [WORD_W-1:0]      i_alu_eval,
    input  logic [ADDR_W-1:0]      i_mem_req_addr,
    input  logic [WORD_W-1:0]      i_mem_req_wr_data,
    input  logic                   i_mem_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_mem_req_count,
    output logic                   o_stall,
    output logic                   o_dmem_valid,
    output logic [ADDR_W-1:0]      o_dmem_addr,
    output logic                   o_dmem_wr_en,
    output logic [WORD_W-1:0]      o_dmem_wr_data,
    output logic [DMEM_BE_W-1:0]   o_dmem_byte_en,
    input  logic                   i_dmem_ready,
    input  logic [WORD_W-1:0]      i_dmem_rd_data,
    output logic [ADDR_W-1:0]      o_pc,
    output logic [INSTR_W-1:0]     o_instr,
    output logic [DEST_SRC_W-1:0]  o_dest_src,
    output logic [REG_IDX_W-1:0]   o_dest_reg,
    output logic [WORD_W-1:0]      o_alu_eval,
    output logic [WORD_W-1:0]      o_mem_data,
    output logic                   o_misaligned
);

    mem_state_t         state;
    logic [ADDR_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_wr_data;
    logic               r_wr_en;
    mem_count_t         r_count;

    mem_count_t         in_count;
    logic               in_misaligned;
    logic               in_is_access;
    logic [WORD_W-1:0]  load_data;
    logic               busy;

    // Classify the op presented by EX so capture can decide whether to start an access
    always_comb begin
        in_count      = mem_count_t'(i_mem_req_count);
        in_misaligned = is_misaligned(in_count, i_mem_req_addr[1:0]);
        in_is_access  = (in_count != MEM_COUNT_NONE) && !in_misaligned;
    end

    mem_stage_load_align u_load_align (
        .rd_word     (i_dmem_rd_data),
        .addr_lo     (r_addr[1:0]),
        .count       (r_count),
        .is_unsigned (r_instr_unsigned()),
        .data        (load_data)
    );

    function automatic logic r_instr_unsigned();
        return o_instr[INSTR_UNSIGNED_BIT];
    endfunction

    // Capture EX results when idle, then hold them while the memory access is outstanding
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= MEM_ST_IDLE;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_count      <= MEM_COUNT_NONE;
            o_pc         <= '0;
            o_instr      <= '0;
            o_dest_src   <= DEST_SRC_NONE;
            o_dest_reg   <= '0;
            o_alu_eval   <= '0;
            o_mem_data   <= '0;
            o_misaligned <= 1'b0;
        end else begin
            case (state)
                MEM_ST_IDLE: begin
                    if (!i_stall) begin
                        r_addr       <= i_mem_req_addr;
                        r_wr_data    <= i_mem_req_wr_data;
                        r_wr_en      <= i_mem_req_wr_en;
                        r_count      <= in_count;
                        o_pc         <= i_pc;
                        o_instr      <= i_instr;
                        o_dest_reg   <= i_dest_reg;
                        o_alu_eval   <= i_alu_eval;
                        o_misaligned <= in_misaligned;
                        // A faulting op must not write back anything
                        o_dest_src   <= in_misaligned ? DEST_SRC_NONE : i_dest_src;
                        if (in_is_access) begin
                            state <= MEM_ST_BUSY;
                        end
                    end
                end
                MEM_ST_BUSY: begin
                    if (i_dmem_ready) begin
                        state <= MEM_ST_IDLE;
                        if (!r_wr_en) begin
                            o_mem_data <= load_data;
                        end
                    end
                end
                default: state <= MEM_ST_IDLE;
            endcase
        end
    end

    // Request fields derive only from registered state so they stay stable across BUSY
    always_comb begin
        busy           = (state == MEM_ST_BUSY);
        o_stall        = busy;
        o_dmem_valid   = busy;
        o_dmem_wr_en   = busy && r_wr_en;
        o_dmem_addr    = {r_addr[ADDR_W-1:2], 2'b00};
        o_dmem_byte_en = '0;
        o_dmem_wr_data = r_wr_data;
        case (r_count)
            MEM_COUNT_BYTE: begin
                o_dmem_byte_en = DMEM_BE_W'(1) << r_addr[1:0];
                o_dmem_wr_data = {4{r_wr_data[7:0]}};
            end
            MEM_COUNT_HALF: begin
                o_dmem_byte_en = DMEM_BE_W'(3) << r_addr[1:0];
                o_dmem_wr_data = {2{r_wr_data[15:0]}};
            end
            MEM_COUNT_WORD: begin
                o_dmem_byte_en = '1;
                o_dmem_wr_data = r_wr_data;
            end
            default: begin
                o_dmem_byte_en = '0;
                o_dmem_wr_data = r_wr_data;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a behavioural model
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                   clk;
    logic                   clr;
    logic                   i_stall;
    logic [ADDR_W-1:0]      i_pc;
    logic [INSTR_W-1:0]     i_instr;
    logic [DEST_SRC_W-1:0]  i_dest_src;
    logic [REG_IDX_W-1:0]   i_dest_reg;
    logic [WORD_W-1:0]      i_alu_eval;
    logic [ADDR_W-1:0]      i_mem_req_addr;
    logic [WORD_W-1:0]      i_mem_req_wr_data;
    logic                   i_mem_req_wr_en;
    logic [MEM_COUNT_W-1:0] i_mem_req_count;
    logic                   o_stall;
    logic                   o_dmem_valid;
    logic [ADDR_W-1:0]      o_dmem_addr;
    logic                   o_dmem_wr_en;
    logic [WORD_W-1:0]      o_dmem_wr_data;
    logic [3:0]             o_dmem_byte_en;
    logic                   i_dmem_ready;
    logic [WORD_W-1:0]      i_dmem_rd_data;
    logic [ADDR_W-1:0]      o_pc;
    logic [INSTR_W-1:0]     o_instr;
    logic [DEST_SRC_W-1:0]  o_dest_src;
    logic [REG_IDX_W-1:0]   o_dest_reg;
    logic [WORD_W-1:0]      o_alu_eval;
    logic [WORD_W-1:0]      o_mem_data;
    logic                   o_misaligned;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_mem = 0;
    logic [31:0] last_pc = 0;

    mem_stage #(.DMEM_BE_W(4)) dut (
        .clk               (clk),
        .clr               (clr),
        .i_stall           (i_stall),
        .i_pc              (i_pc),
        .i_instr           (i_instr),
        .i_dest_src        (i_dest_src),
        .i_dest_reg        (i_dest_reg),
        .i_alu_eval        (i_alu_eval),
        .i_mem_req_addr    (i_mem_req_addr),
        .i_mem_req_wr_data (i_mem_req_wr_data),
        .i_mem_req_wr_en   (i_mem_req_wr_en),
        .i_mem_req_count   (i_mem_req_count),
        .o_stall           (o_stall),
        .o_dmem_valid      (o_dmem_valid),
        .o_dmem_addr       (o_dmem_addr),
        .o_dmem_wr_en      (o_dmem_wr_en),
        .o_dmem_wr_data    (o_dmem_wr_data),
        .o_dmem_byte_en    (o_dmem_byte_en),
        .i_dmem_ready      (i_dmem_ready),
        .i_dmem_rd_data    (i_dmem_rd_data),
        .o_pc              (o_pc),
        .o_instr           (o_instr),
        .o_dest_src        (o_dest_src),
        .o_dest_reg        (o_dest_reg),
        .o_alu_eval        (o_alu_eval),
        .o_mem_data        (o_mem_data),
        .o_misaligned      (o_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] cnt);
        return (cnt == 2'd1) ? 1 : (cnt == 2'd2) ? 2 : (cnt == 2'd3) ? 4 : 0;
    endfunction

    function automatic logic [31:0] model_be(input logic [1:0] cnt, input logic [1:0] a);
        return ((32'd1 << size_of(cnt)) - 32'd1) << a;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] cnt, input logic [31:0] d);
        if (cnt == 2'd1) return (d & 32'hFF) * 32'h01010101;
        if (cnt == 2'd2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] cnt, input logic [1:0] a,
                                               input logic uns, input logic [31:0] rd);
        int          bits;
        logic [31:0] v;
        logic [31:0] mask;
        bits = size_of(cnt) * 8;
        if (bits == 32) return rd;
        v    = rd / (32'd1 << (a * 8));
        mask = (32'd1 << bits) - 32'd1;
        v    = v & mask;
        if (!uns && v >= (32'd1 << (bits - 1))) v = v | ~mask;
        return v;
    endfunction

    task automatic scramble_inputs();
        i_pc              = $urandom;
        i_instr           = $urandom;
        i_dest_src        = DEST_SRC_W'($urandom);
        i_dest_reg        = REG_IDX_W'($urandom);
        i_alu_eval        = $urandom;
        i_mem_req_addr    = $urandom;
        i_mem_req_wr_data = $urandom;
        i_mem_req_wr_en   = 1'($urandom);
        i_mem_req_count   = 2'($urandom);
    endtask

    task automatic run_op(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wr, input logic [1:0] cnt, input logic uns,
                          input int n, input logic [31:0] rd);
        logic [31:0] pc, instr, alu;
        logic [4:0]  dreg;
        logic [1:0]  dsrc;
        logic        mis, active;
        pc    = $urandom;
        instr = $urandom;
        instr[14] = uns;
        alu   = $urandom;
        dreg  = 5'($urandom);
        dsrc  = 2'($urandom_range(1, 3));
        mis    = (cnt == 2'd2 && addr[0]) || (cnt == 2'd3 && addr[1:0] != 2'b00);
        active = (cnt != 2'd0) && !mis;

        i_stall = 1'b0; i_dmem_ready = 1'b0;
        i_pc = pc; i_instr = instr; i_alu_eval = alu; i_dest_reg = dreg; i_dest_src = dsrc;
        i_mem_req_addr = addr; i_mem_req_wr_data = wdata; i_mem_req_wr_en = wr;
        i_mem_req_count = cnt;
        @(posedge clk); #1;
        last_pc = pc;
        check({nm, " pc"}, o_pc, pc);
        check({nm, " instr"}, o_instr, instr);
        check({nm, " alu"}, o_alu_eval, alu);
        check({nm, " dest_reg"}, 32'(o_dest_reg), 32'(dreg));
        check({nm, " dest_src"}, 32'(o_dest_src), mis ? 32'd0 : 32'(dsrc));
        check({nm, " misaligned"}, 32'(o_misaligned), 32'(mis));

        if (active) begin
            // Inputs and i_stall must be ignored while the access is outstanding
            scramble_inputs();
            i_stall = 1'($urandom);
            for (int k = 1; k <= n; k++) begin
                check({nm, " valid"}, 32'(o_dmem_valid), 32'd1);
                check({nm, " stall"}, 32'(o_stall), 32'd1);
                check({nm, " addr"}, o_dmem_addr, addr & 32'hFFFF_FFFC);
                check({nm, " byte_en"}, 32'(o_dmem_byte_en), model_be(cnt, addr[1:0]));
                check({nm, " wr_en"}, 32'(o_dmem_wr_en), 32'(wr));
                if (wr) check({nm, " wr_data"}, o_dmem_wr_data, model_wdata(cnt, wdata));
                i_dmem_ready   = (k == n);
                i_dmem_rd_data = (k == n) ? rd : $urandom;
                @(posedge clk); #1;
            end
            i_dmem_ready = 1'b0;
            i_stall      = 1'b1;
            if (!wr) exp_mem = model_load(cnt, addr[1:0], uns, rd);
            check({nm, " done valid"}, 32'(o_dmem_valid), 32'd0);
            check({nm, " done stall"}, 32'(o_stall), 32'd0);
            check({nm, " mem_data"}, o_mem_data, exp_mem);
            check({nm, " pc held"}, o_pc, pc);
        end else begin
            check({nm, " idle valid"}, 32'(o_dmem_valid), 32'd0);
            check({nm, " idle stall"}, 32'(o_stall), 32'd0);
            check({nm, " mem_data kept"}, o_mem_data, exp_mem);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " stall"}, 32'(o_stall), 32'd0);
        check({nm, " valid"}, 32'(o_dmem_valid), 32'd0);
        check({nm, " pc"}, o_pc, 32'd0);
        check({nm, " instr"}, o_instr, 32'd0);
        check({nm, " dest_src"}, 32'(o_dest_src), 32'(DEST_SRC_NONE));
        check({nm, " dest_reg"}, 32'(o_dest_reg), 32'd0);
        check({nm, " alu"}, o_alu_eval, 32'd0);
        check({nm, " mem_data"}, o_mem_data, 32'd0);
        check({nm, " misaligned"}, 32'(o_misaligned), 32'd0);
    endtask

    initial begin
        clr = 1'b1; i_stall = 1'b0; i_dmem_ready = 1'b0; i_dmem_rd_data = '0;
        scramble_inputs();

        // Reset with inputs toggling
        for (int c = 0; c < 2; c++) begin
            scramble_inputs();
            i_stall = 1'($urandom);
            i_dmem_ready = 1'($urandom);
            i_dmem_rd_data = $urandom;
            @(posedge clk); #1;
            check_all_zero("reset");
        end
        clr = 1'b0;
        exp_mem = 0;

        // Directed cases
        run_op("LW",  32'h100, 32'h0, 1'b0, 2'd3, 1'b0, 3, 32'hDEADBEEF);
        run_op("LB",  32'h103, 32'h0, 1'b0, 2'd1, 1'b0, 1, 32'h80123456);
        run_op("LBU", 32'h103, 32'h0, 1'b0, 2'd1, 1'b1, 2, 32'h80123456);
        run_op("LHU", 32'h102, 32'h0, 1'b0, 2'd2, 1'b1, 1, 32'h80123456);
        run_op("SB",  32'h201, 32'hA5, 1'b1, 2'd1, 1'b0, 2, 32'h12345678);
        run_op("LWmis", 32'h102, 32'h0, 1'b0, 2'd3, 1'b0, 1, 32'h0);
        run_op("NOP", 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 1, 32'h0);

        // Downstream hold in IDLE: nothing captured, no request
        i_stall = 1'b1;
        scramble_inputs();
        i_pc = ~last_pc;
        i_mem_req_count = 2'd1;
        @(posedge clk); #1;
        check("hold pc", o_pc, last_pc);
        check("hold valid", 32'(o_dmem_valid), 32'd0);

        // Randomized ops
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_op("rand", a, $urandom, 1'($urandom), 2'($urandom), 1'($urandom),
                   int'($urandom_range(1, 4)), $urandom);
        end

        // clr in the second BUSY cycle, together with ready, abandons the access
        i_stall = 1'b0; i_dmem_ready = 1'b0;
        scramble_inputs();
        i_mem_req_addr = 32'h300; i_mem_req_count = 2'd3; i_mem_req_wr_en = 1'b0;
        @(posedge clk); #1;
        check("abort busy1 valid", 32'(o_dmem_valid), 32'd1);
        @(posedge clk); #1;
        check("abort busy2 valid", 32'(o_dmem_valid), 32'd1);
        clr = 1'b1; i_dmem_ready = 1'b1; i_dmem_rd_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        clr = 1'b0; i_dmem_ready = 1'b0;
        i_stall = 1'b1;
        exp_mem = 0;
        check_all_zero("abort");
        i_dmem_ready = 1'b1; i_dmem_rd_data = 32'h55AA55AA;
        @(posedge clk); #1;
        i_dmem_ready = 1'b0;
        check("late ready mem_data", o_mem_data, 32'd0);
        check("late ready valid", 32'(o_dmem_valid), 32'd0);
        check("late ready stall", 32'(o_stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
